// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and baud/parity helpers.
// UART_TX_PARITY_EN adds the PARITY state used by frames that carry an even-parity bit.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } uart_state_t;

    // Baud counter width; a counter needs at least one bit even for tiny ratios.
    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the UART transmitter: byte push plus FIFO level flags.
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;

    modport master (output wr_en, output wr_data, input full, input empty);
    modport slave  (input wr_en, input wr_data, output full, output empty);

endinterface

// File: rtl/uart_byte_fifo.sv
// Generic 2**DEPTH_LOG2 x 8 synchronous FIFO with registered full/empty flags.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [DATA_W-1:0]     mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r, count_s;
    logic                  full_r, empty_r, do_push_s, do_pop_s;

    // A push into a full FIFO is still taken when the same-cycle pop frees a slot.
    always_comb begin
        do_pop_s  = pop && !empty_r;
        do_push_s = push && (!full_r || do_pop_s);
        case ({do_push_s, do_pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // Pointers, occupancy and flags; flags follow the next count so they are never stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {(DEPTH_LOG2 + 1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_s;
            full_r  <= (count_s == CNT_FULL);
            empty_r <= (count_s == {(DEPTH_LOG2 + 1){1'b0}});
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_data;
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser with registered tx.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1, 11 bit times per frame).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ    = 100000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus,
    output logic          busy,
    output logic          tx
);
    // CLKS_PER_BIT must be at least 2 for the registered pop to settle between frames.
    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);

    uart_state_t       state_r, state_s;
    logic [CNT_W-1:0]  baud_r, baud_s;
    logic [2:0]        idx_r, idx_s;
    logic [DATA_W-1:0] shift_r, shift_s, head_s;
    logic              tx_r, tx_s, busy_r, busy_s, pop_r, pop_s, load_s, bit_end_s;
    logic              fifo_full_s, fifo_empty_s;
`ifdef UART_TX_PARITY_EN
    logic              parity_r, parity_s;
`endif

    uart_byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (pop_r),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign bus.full  = fifo_full_s;
    assign bus.empty = fifo_empty_s;
    assign bit_end_s = (baud_r == BAUD_LAST);

    // Frame sequencing: next state, line level and the pop request for the head byte.
    always_comb begin
        state_s  = state_r;
        baud_s   = baud_r + BAUD_ONE;
        idx_s    = idx_r;
        shift_s  = shift_r;
        tx_s     = tx_r;
        busy_s   = busy_r;
        load_s   = 1'b0;
        pop_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_s = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                baud_s = {CNT_W{1'b0}};
                if (!fifo_empty_s) begin
                    load_s = 1'b1;
                end else begin
                    busy_s = 1'b0;
                    tx_s   = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s = ST_DATA;
                    baud_s  = {CNT_W{1'b0}};
                    idx_s   = 3'd0;
                    tx_s    = shift_r[0];
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_s = {CNT_W{1'b0}};
                    if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_s = ST_PARITY;
                        tx_s    = parity_r;
`else
                        state_s = ST_STOP;
                        tx_s    = 1'b1;
`endif
                    end else begin
                        shift_s = shift_r >> 1;
                        idx_s   = idx_r + 3'd1;
                        tx_s    = shift_r[1];
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_s = ST_STOP;
                    baud_s  = {CNT_W{1'b0}};
                    tx_s    = 1'b1;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_s = {CNT_W{1'b0}};
                    if (!fifo_empty_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        busy_s  = 1'b0;
                        tx_s    = 1'b1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = {CNT_W{1'b0}};
                busy_s  = 1'b0;
                tx_s    = 1'b1;
            end
        endcase
        // Starting a frame captures the head byte now; the FIFO pops it one edge later.
        if (load_s) begin
            state_s  = ST_START;
            pop_s    = 1'b1;
            shift_s  = head_s;
            idx_s    = 3'd0;
            baud_s   = {CNT_W{1'b0}};
            tx_s     = 1'b0;
            busy_s   = 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_s = even_parity(head_s);
`endif
        end else begin
            pop_s = 1'b0;
        end
    end

    // Serialiser state register; reset abandons any frame and forces the line idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            baud_r   <= {CNT_W{1'b0}};
            idx_r    <= 3'd0;
            shift_r  <= {DATA_W{1'b0}};
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
            pop_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            baud_r   <= baud_s;
            idx_r    <= idx_s;
            shift_r  <= shift_s;
            tx_r     <= tx_s;
            busy_r   <= busy_s;
            pop_r    <= pop_s;
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_s;
`endif
        end
    end

    assign busy = busy_r;
    assign tx   = tx_r;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte-wide transmit FIFO followed by a UART serialiser. It drives the riscv_top Tx pin: the CPU I/O controller pushes output bytes in, and the block shifts them out as 8N1 frames. The simulation testbench samples this line, and a synthesised build sends it to the host. The block buffers bursts so the CPU stalls only when the FIFO is full.

Parameters:
SYS_CLK_FREQ, 100000000, clock frequency in Hz.
BAUD_RATE, 115200, line rate in bit/s.
FIFO_DEPTH_LOG2, 4, FIFO holds 2**FIFO_DEPTH_LOG2 bytes.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
wr_en  in  1  push wr_data this cycle.
wr_data  in  8  byte to transmit.
full  out  1  FIFO holds DEPTH bytes.
empty  out  1  FIFO holds 0 bytes.
busy  out  1  serialiser mid-frame.
tx  out  1  serial line, idle high.

Behaviour:
- Reset values: tx=1, busy=0, full=0, empty=1. Read and write pointers, count, FSM state and baud counter all clear.
- Reset is asynchronous and may arrive mid-frame. The frame is abandoned, tx returns to 1 immediately, and FIFO contents are discarded.
- Derived constants:
  - CLKS_PER_BIT = SYS_CLK_FREQ/BAUD_RATE, integer division, must be ≥2.
  - Baud counter width = clog2(CLKS_PER_BIT).
- FIFO:
  - Circular buffer with an FIFO_DEPTH_LOG2-bit pointer and a (FIFO_DEPTH_LOG2+1)-bit count.
  - Pointers wrap modulo DEPTH.
  - full and empty are registered and derived from the next count.
- Push while full and no pop in the same cycle: the byte is dropped. No state changes and no error flag is raised.
- Push and pop in the same cycle: both take effect and count is unchanged. This holds when full as well; the pop frees the slot the push uses.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if !empty, pop the head byte into an 8-bit shift register, set tx=0 and busy=1, clear the baud counter, go to START.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=shift[0].
  - DATA: each bit lasts CLKS_PER_BIT cycles, LSB first. At each bit end, shift right and increment a 3-bit index. After bit 7, go to STOP with tx=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. Then:
    - if !empty, pop the next byte and go directly to START (back-to-back frames with no idle gap);
    - otherwise go to IDLE with busy=0.
- Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE is visible at edge N+1. tx falls at edge N+1, and empty returns to 1 at N+2.
- Frame length is exactly 10*CLKS_PER_BIT cycles. busy stays high for the whole frame.
- tx is registered (glitch-free pin drive).

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. tx is the XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT.
- Undefined: the PARITY state and its logic are absent. The frame is 8N1 at 10 bit times.

Decomposition:
- Shared package (uart_pkg): FSM state encoding, data width 8, and a clog2-based CLKS_PER_BIT width helper. The future uart_rx reuses it.
- One natural sub-module: uart_byte_fifo, a generic DEPTH×8 synchronous FIFO with push/pop/full/empty. uart_tx_fifo instantiates it and holds the FSM and baud counter.

Test Plan:
Test parameters: SYS_CLK_FREQ=16, BAUD_RATE=4, giving CLKS_PER_BIT=4.
- Reset, then idle 20 cycles -> tx=1, busy=0, empty=1, full=0 throughout.
- Push 0x55 once -> tx sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles). busy=1 from edge N+1 to N+40, then busy=0 and tx=1.
- Push 0xA3 then 0x0F on consecutive cycles -> two frames with no idle gap: 0,1,1,0,0,0,1,0,1,1 then 0,1,1,1,1,0,0,0,0,1. empty=1 after the second pop.
- With FIFO_DEPTH_LOG2=2 and the FSM busy:
  - push 5 bytes (0x01..0x05) -> full=1 after the 4th; 0x05 dropped; 0x01..0x04 transmitted in order.
  - push while full in the same cycle as a pop -> byte accepted; full stays 1.
- Assert rst during DATA bit 3 of 0xFF -> tx=1 in the same cycle (asynchronous). After release: empty=1, busy=0, no further frame.
- With UART_TX_PARITY_EN, push 0x07 -> frame 0,1,1,1,0,0,0,0,0,1,1 (parity=1), 44 cycles.
